door_lock_supervisor: RTL and testbench

Downstream stage of the serial-code door lock. Consumes the lock's `unlock` and `error` outputs, drives the physical door-release line for a fixed hold time, and counts consecutive failed code attempts. After `MAX_FAIL` consecutive failures it enters a timed lockout that ignores all further attempts, with an optional alarm.

---
 rtl/door_lock_supervisor.sv | 181 ++++++++++++++++++
 tb/tb_door_lock_supervisor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/door_lock_supervisor.sv
// -----------------------------------------------------------------------------
// door_lock_supervisor
//
// Downstream stage of the serial-code door lock. Turns the lock's unlock/error
// outputs into a timed door-release drive, counts consecutive failed attempts
// and, after MAX_FAIL of them, holds a timed lockout during which every attempt
// is ignored.
//
// Optional feature macro: DOOR_ALARM_EN
//   defined   -> alarm is a registered copy of the lockout indication
//   undefined -> alarm is tied low and no alarm register exists
//
// Ports
//   clk         in   system clock, all state changes on the rising edge
//   reset       in   asynchronous, active-low reset
//   unlock      in   unlock indication from the lock (pulse or level)
//   error       in   error indication from the lock (pulse or level)
//   door_open   out  door-release drive (state == OPEN)
//   locked_out  out  high while in lockout (state == LOCKOUT)
//   alarm       out  lockout alarm (see macro above)
//   fail_count  out  current consecutive-failure count
//   dbg_state   out  raw FSM state register for observation
//
// Input handshake: there is no valid/ready pair. unlock and error are treated
// as level signals whose 0->1 transitions (seen against a registered copy) are
// the events; a level held high is one event, and a level already high on the
// first clock after reset is an event because the copies reset to 0.
// -----------------------------------------------------------------------------
module door_lock_supervisor #(
  parameter int MAX_FAIL       = 3,
  parameter int FAIL_W         = 2,
  parameter int OPEN_CYCLES    = 10,
  parameter int LOCKOUT_CYCLES = 20,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              unlock,
  input  logic              error,
  output logic              door_open,
  output logic              locked_out,
  output logic              alarm,
  output logic [FAIL_W-1:0] fail_count,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OPEN    = 2'd1,
    S_LOCKOUT = 2'd2
  } state_e;

  localparam logic [FAIL_W-1:0] MAX_FAIL_C = FAIL_W'(MAX_FAIL);
  localparam logic [CNT_W-1:0]  OPEN_LOAD  = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOCK_LOAD  = CNT_W'(LOCKOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  timer_q, timer_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic              unlock_q, error_q;

  logic              unlock_ev, error_ev;
  logic [FAIL_W-1:0] fail_inc;
  logic [CNT_W-1:0]  timer_dec;

  // Edge registers keep tracking the inputs in every state, including lockout,
  // so a level still high when lockout ends does not count as a new event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      unlock_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      unlock_q <= unlock;
      error_q  <= error;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    unlock_ev = unlock & ~unlock_q;
    error_ev  = error & ~error_q;
    // Saturating increment: the count parks at MAX_FAIL and never wraps.
    fail_inc  = (fail_q < MAX_FAIL_C) ? fail_q + 1'b1 : fail_q;
    timer_dec = (timer_q != '0) ? timer_q - 1'b1 : '0;

    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;

    case (state_q)
      S_IDLE: begin
        // Error takes priority; a simultaneous unlock is dropped.
        if (error_ev) begin
          fail_d = fail_inc;
          if (fail_inc == MAX_FAIL_C) begin
            state_d = S_LOCKOUT;
            timer_d = LOCK_LOAD;
          end
        end else if (unlock_ev) begin
          state_d = S_OPEN;
          timer_d = OPEN_LOAD;
          fail_d  = '0;
        end
      end

      S_OPEN: begin
        if (error_ev) begin
          // Abort the open immediately and count the failure.
          fail_d = fail_inc;
          if (fail_inc == MAX_FAIL_C) begin
            state_d = S_LOCKOUT;
            timer_d = LOCK_LOAD;
          end else begin
            state_d = S_IDLE;
            timer_d = '0;
          end
        end else if (unlock_ev) begin
          // Retrigger, including on the cycle the timer has reached zero.
          timer_d = OPEN_LOAD;
        end else if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_dec;
        end
      end

      S_LOCKOUT: begin
        // Events are ignored here; only the timer matters.
        if (timer_q == '0) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          timer_d = timer_dec;
        end
      end

      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        fail_d  = '0;
      end
    endcase
  end

  // Outputs come from registers only; no combinational path from the inputs.
  assign door_open  = (state_q == S_OPEN);
  assign locked_out = (state_q == S_LOCKOUT);
  assign fail_count = fail_q;
  assign dbg_state  = state_q;

`ifdef DOOR_ALARM_EN
  logic alarm_q;

  // Registered from the next state so it lines up cycle-for-cycle with
  // locked_out. An unlock attempt during lockout would latch the alarm until
  // lockout ends, which this already does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= (state_d == S_LOCKOUT);
    end
  end

  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_door_lock_supervisor.sv
module tb_door_lock_supervisor;

  localparam int MAX_FAIL       = 3;
  localparam int FAIL_W         = 2;
  localparam int OPEN_CYCLES    = 10;
  localparam int LOCKOUT_CYCLES = 20;
  localparam int CNT_W          = 8;
  localparam int EW             = 3 + FAIL_W;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              unlock;
  logic              error;
  logic              door_open;
  logic              locked_out;
  logic              alarm;
  logic [FAIL_W-1:0] fail_count;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  door_lock_supervisor #(
    .MAX_FAIL      (MAX_FAIL),
    .FAIL_W        (FAIL_W),
    .OPEN_CYCLES   (OPEN_CYCLES),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .unlock    (unlock),
    .error     (error),
    .door_open (door_open),
    .locked_out(locked_out),
    .alarm     (alarm),
    .fail_count(fail_count),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------- reference model ----------------
  // Tracks remaining open / lockout cycles rather than any state encoding.
  int m_open_left;   // cycles door_open remains high, counting the current one
  int m_lock_left;   // cycles locked_out remains high, counting the current one
  int m_fail;
  bit m_pu, m_pe;    // last sampled input levels

  function automatic bit alarm_model(int lock_left);
`ifdef DOOR_ALARM_EN
    return lock_left > 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_open_left = 0;
    m_lock_left = 0;
    m_fail      = 0;
    m_pu        = 1'b0;
    m_pe        = 1'b0;
  endtask

  task automatic model_step(input bit u, input bit e);
    bit ue, ee;
    ue   = u && !m_pu;
    ee   = e && !m_pe;
    m_pu = u;
    m_pe = e;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fail = 0;
    end else if (ee) begin
      m_fail      = (m_fail + 1 > MAX_FAIL) ? MAX_FAIL : m_fail + 1;
      m_open_left = 0;
      if (m_fail == MAX_FAIL) m_lock_left = LOCKOUT_CYCLES;
    end else if (ue) begin
      m_fail      = 0;
      m_open_left = OPEN_CYCLES;
    end else if (m_open_left > 0) begin
      m_open_left--;
    end
  endtask

  function automatic logic [EW-1:0] model_out();
    logic [FAIL_W-1:0] f;
    f = FAIL_W'(m_fail);
    return {m_open_left > 0, m_lock_left > 0, alarm_model(m_lock_left), f};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit u, input bit e);
    @(negedge clk);
    unlock = u;
    error  = e;
    model_step(u, e);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
  endtask

  task automatic check_now(input string name, input logic [EW-1:0] act,
                           input logic [EW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [EW-1:0] exp_v;
    #2;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check_now("outputs{door,lock,alarm,fail}",
                {door_open, locked_out, alarm, fail_count}, exp_v);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    reset  = 1'b0;
    unlock = 1'b0;
    error  = 1'b0;
    #1;
    check_now("reset_state", {door_open, locked_out, alarm, fail_count}, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // single unlock pulse
    drive(1'b1, 1'b0);
    idle(12);

    // two errors then unlock
    drive(1'b0, 1'b1); idle(3);
    drive(1'b0, 1'b1); idle(3);
    drive(1'b1, 1'b0); idle(12);

    // three errors 10 apart -> lockout, unlock attempts inside the window
    drive(1'b0, 1'b1); idle(9);
    drive(1'b0, 1'b1); idle(9);
    drive(1'b0, 1'b1); idle(3);
    drive(1'b1, 1'b0); idle(4);
    drive(1'b1, 1'b0); idle(25);

    // held unlock: one open only
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b0);
    idle(12);
    // retrigger on cycle 6 of OPEN
    drive(1'b1, 1'b0); idle(5);
    drive(1'b1, 1'b0); idle(20);

    // error during OPEN, then simultaneous unlock+error from IDLE
    drive(1'b1, 1'b0); idle(3);
    drive(1'b0, 1'b1); idle(5);
    drive(1'b1, 1'b1); idle(4);

    // clear count, reach lockout, then async reset mid-lockout
    drive(1'b1, 1'b0); idle(12);
    drive(1'b0, 1'b1); idle(2);
    drive(1'b0, 1'b1); idle(2);
    drive(1'b0, 1'b1); idle(5);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_now("async_reset_mid_lockout",
              {door_open, locked_out, alarm, fail_count}, '0);
    exp_q.delete();
    model_reset();
    unlock = 1'b0;
    error  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 1'b0); idle(12);

    // randomized traffic: short pulses and occasional held levels
    for (int i = 0; i < 1500; i++) begin
      bit u, e;
      u = ($urandom_range(0, 99) < 12);
      e = ($urandom_range(0, 99) < 8);
      drive(u, e);
    end
    idle(30);

    @(posedge clk);
    #4;
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL queue_drain actual=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
